// File: rtl/otter_cache_pkg.sv
// Shared geometry, FSM encoding and address-field helpers for the OTTER
// instruction cache.
package otter_cache_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINES  = 16;
  localparam int unsigned WORDS  = 8;

  localparam int unsigned WOFF_W = $clog2(WORDS);
  localparam int unsigned IDX_W  = $clog2(LINES);
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - WOFF_W - 2;

  // Clears word and byte offset bits to give the line base address.
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(WORDS * 4 - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_t;

  function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] get_idx(input logic [ADDR_W-1:0] a);
    return a[2 + WOFF_W +: IDX_W];
  endfunction

  function automatic logic [WOFF_W-1:0] get_word(input logic [ADDR_W-1:0] a);
    return a[2 +: WOFF_W];
  endfunction

endpackage

// File: rtl/otter_icache_if.sv
// Fetch-side and memory-side buses of the instruction cache; the master is
// the side that issues requests.
interface otter_fetch_if;
  import otter_cache_pkg::*;

  logic              fetch_re;
  logic [ADDR_W-1:0] fetch_addr;
  logic [31:0]       fetch_data;
  logic              stall;

  modport master (output fetch_re, fetch_addr, input fetch_data, stall);
  modport slave  (input fetch_re, fetch_addr, output fetch_data, stall);
endinterface

interface otter_mem_if;
  import otter_cache_pkg::*;

  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              mem_valid;

  modport master (output mem_re, mem_addr, input mem_rdata, mem_valid);
  modport slave  (input mem_re, mem_addr, output mem_rdata, mem_valid);
endinterface

// File: rtl/otter_icache_fsm.sv
// Miss handler: sequences a word-serial line fill from memory and produces
// the array write strobes.
module otter_icache_fsm
  import otter_cache_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              mem_valid,
  output state_t            state,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] base,
  output logic [WOFF_W-1:0] cnt,
  output logic              data_we_c,
  output logic              line_we_c
);

  // Memory data is only honoured while a request is outstanding.
  assign data_we_c = (state == FILL) & mem_re & mem_valid;
  assign line_we_c = data_we_c & (cnt == WOFF_W'(WORDS - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      mem_re   <= 1'b0;
      mem_addr <= '0;
      base     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            base     <= fetch_addr & LINE_MASK;
            mem_addr <= fetch_addr & LINE_MASK;
            cnt      <= '0;
            mem_re   <= 1'b1;
            state    <= FILL;
          end
        end
        FILL: begin
          if (data_we_c) begin
            cnt <= cnt + WOFF_W'(1);
            if (line_we_c) begin
              mem_re <= 1'b0;
              state  <= DONE;
            end else begin
              mem_addr <= base + ADDR_W'({cnt + WOFF_W'(1), 2'b00});
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/otter_icache.sv
// Direct-mapped read-only instruction cache for the OTTER fetch stage: hits
// return in the same cycle, misses stall while a line is burst-filled.
module otter_icache
  import otter_cache_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                invalidate,
  otter_fetch_if.slave        fetch,
  otter_mem_if.master         mem,
  output logic [31:0]         hit_cnt,
  output logic [31:0]         miss_cnt
);

  logic [31:0]       data_mem [LINES][WORDS];
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINES-1:0]  valid;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [WOFF_W-1:0] cnt;
  logic              data_we_c;
  logic              line_we_c;

  logic [IDX_W-1:0]  idx_c;
  logic [IDX_W-1:0]  fill_idx_c;
  logic              look_c;
  logic              hit_c;
  logic              miss_c;

  assign idx_c      = get_idx(fetch.fetch_addr);
  assign fill_idx_c = get_idx(base);

  // Lookup only happens in IDLE and sees valid bits from before any same-cycle invalidate.
  assign look_c = reset_n & (state == IDLE) & fetch.fetch_re;
  assign hit_c  = look_c & valid[idx_c] & (tag_mem[idx_c] == get_tag(fetch.fetch_addr));
  assign miss_c = look_c & ~hit_c;

  assign fetch.fetch_data = hit_c ? data_mem[idx_c][get_word(fetch.fetch_addr)] : 32'h0;
  assign fetch.stall      = reset_n & (miss_c | (state != IDLE));

  otter_icache_fsm u_fsm (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (miss_c),
    .fetch_addr (fetch.fetch_addr),
    .mem_valid  (mem.mem_valid),
    .state      (state),
    .mem_re     (mem.mem_re),
    .mem_addr   (mem.mem_addr),
    .base       (base),
    .cnt        (cnt),
    .data_we_c  (data_we_c),
    .line_we_c  (line_we_c)
  );

  // Data and tag storage carry no reset; the valid vector guards them.
  always_ff @(posedge clk) begin
    if (data_we_c) data_mem[fill_idx_c][cnt] <= mem.mem_rdata;
    if (line_we_c) tag_mem[fill_idx_c] <= get_tag(base);
  end

  // An invalidate coinciding with the final fill word leaves the line invalid.
  always_ff @(posedge clk) begin
    if (!reset_n)        valid <= '0;
    else if (invalidate) valid <= '0;
    else if (line_we_c)  valid[fill_idx_c] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit_c && (hit_cnt != 32'hFFFF_FFFF))   hit_cnt  <= hit_cnt + 32'd1;
      if (miss_c && (miss_cnt != 32'hFFFF_FFFF)) miss_cnt <= miss_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_otter_icache.sv
// Self-checking bench for otter_icache: table-driven fetch vectors plus
// hand-written invalidate and reset-abort sequences against a memory model.
module tb_otter_icache;
  import otter_cache_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        invalidate = 1'b0;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  otter_fetch_if fif ();
  otter_mem_if   mif ();

  otter_icache dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .invalidate (invalidate),
    .fetch      (fif.slave),
    .mem        (mif.master),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          lat = 2;
  int          wait_c = 0;
  bit          inv_last_arm = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] addr_log[$];

  typedef struct {
    logic [31:0] addr;
    int          lat;
    bit          inv;
    int          stall;
    logic [31:0] hits;
    logic [31:0] misses;
  } vec_t;

  vec_t vt[7];

  function automatic logic [31:0] memword(input logic [31:0] a);
    return 32'h1000_0000 + ((a - 32'h100) >> 2);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder: each word answers after `lat` cycles of MEM_RE.
  task automatic mem_model();
    invalidate = 1'b0;
    if (mif.mem_re === 1'b1) begin
      if (mif.mem_valid) begin
        mif.mem_valid = 1'b0;
        wait_c = 0;
      end
      wait_c++;
      if (wait_c >= lat) begin
        mif.mem_valid = 1'b1;
        mif.mem_rdata = memword(mif.mem_addr);
        if (inv_last_arm && (mif.mem_addr[4:2] == 3'd7)) begin
          invalidate   = 1'b1;
          inv_last_arm = 1'b0;
        end
      end
    end else begin
      mif.mem_valid = 1'b0;
      wait_c = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mem_model();
  endtask

  // Holds a fetch until STALL drops; returns the number of stalled cycles.
  task automatic do_fetch(input logic [31:0] a, input bit inv_same, output int stalls);
    logic [31:0] e;
    bit          done;
    done = 1'b0;
    stalls = 0;
    exp_q.push_back(memword(a));
    addr_log.delete();
    fif.fetch_re   = 1'b1;
    fif.fetch_addr = a;
    invalidate     = inv_same;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (mif.mem_re && mif.mem_valid) addr_log.push_back(mif.mem_addr);
      if (!fif.stall) begin
        e = exp_q.pop_front();
        check("fetch_data", fif.fetch_data, e);
        done = 1'b1;
      end else begin
        stalls++;
      end
      tick();
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL fetch_timeout: addr %h still stalled after 400 cycles", a);
      exp_q.delete();
    end
    fif.fetch_re = 1'b0;
  endtask

  task automatic check_fill(input logic [31:0] a);
    check("fill_words", 32'(addr_log.size()), 32'd8);
    for (int i = 0; i < addr_log.size(); i++)
      check("fill_addr", addr_log[i], (a & 32'hFFFF_FFE0) + 32'(4 * i));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int st;
    int vcount;

    vt[0] = '{32'h0000_0104, 2, 1'b0, 18, 32'd1, 32'd1};
    vt[1] = '{32'h0000_0100, 2, 1'b0,  0, 32'd2, 32'd1};
    vt[2] = '{32'h0000_0108, 2, 1'b0,  0, 32'd3, 32'd1};
    vt[3] = '{32'h0000_011C, 2, 1'b0,  0, 32'd4, 32'd1};
    vt[4] = '{32'h0000_0304, 1, 1'b0, 10, 32'd5, 32'd2};
    vt[5] = '{32'h0000_0104, 3, 1'b0, 26, 32'd6, 32'd3};
    vt[6] = '{32'h0000_0104, 1, 1'b1, 10, 32'd7, 32'd4};

    fif.fetch_re   = 1'b0;
    fif.fetch_addr = '0;
    mif.mem_valid  = 1'b0;
    mif.mem_rdata  = '0;
    reset_n        = 1'b0;
    repeat (3) tick();
    check("rst_mem_re", 32'(mif.mem_re), 32'd0);
    check("rst_mem_addr", mif.mem_addr, 32'h0);
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
    check("rst_stall", 32'(fif.stall), 32'd0);
    check("rst_fetch_data", fif.fetch_data, 32'h0);
    reset_n = 1'b1;
    tick();

    for (int k = 0; k < 7; k++) begin
      lat = vt[k].lat;
      if (vt[k].inv) begin
        invalidate = 1'b1;
        tick();
      end
      do_fetch(vt[k].addr, 1'b0, st);
      check("stall_cycles", 32'(st), 32'(vt[k].stall));
      check("hit_cnt", hit_cnt, vt[k].hits);
      check("miss_cnt", miss_cnt, vt[k].misses);
      if (vt[k].stall != 0) check_fill(vt[k].addr);
    end

    // Invalidate together with a lookup: lookup still hits, the next one misses.
    lat = 1;
    do_fetch(32'h104, 1'b1, st);
    check("inv_same_stall", 32'(st), 32'd0);
    check("inv_same_hit", hit_cnt, 32'd8);
    do_fetch(32'h104, 1'b0, st);
    check("inv_after_stall", 32'(st), 32'd10);
    check("inv_after_miss", miss_cnt, 32'd5);
    check("inv_after_hit", hit_cnt, 32'd9);

    // Invalidate on the last fill word forces a second fill.
    invalidate = 1'b1;
    tick();
    inv_last_arm = 1'b1;
    do_fetch(32'h104, 1'b0, st);
    check("inv_last_stall", 32'(st), 32'd20);
    check("inv_last_words", 32'(addr_log.size()), 32'd16);
    check("inv_last_miss", miss_cnt, 32'd7);
    check("inv_last_hit", hit_cnt, 32'd10);

    // Reset after the third fill word aborts the fill.
    lat = 2;
    vcount = 0;
    fif.fetch_re   = 1'b1;
    fif.fetch_addr = 32'h504;
    for (int c = 0; c < 100 && vcount < 3; c++) begin
      @(negedge clk);
      if (mif.mem_re && mif.mem_valid) vcount++;
      tick();
    end
    check("abort_words_seen", 32'(vcount), 32'd3);
    reset_n = 1'b0;
    tick();
    check("abort_mem_re", 32'(mif.mem_re), 32'd0);
    check("abort_stall", 32'(fif.stall), 32'd0);
    check("abort_fetch_data", fif.fetch_data, 32'h0);
    fif.fetch_re  = 1'b0;
    reset_n       = 1'b1;
    mif.mem_valid = 1'b1;
    mif.mem_rdata = 32'hDEAD_BEEF;
    tick();
    check("late_valid_mem_re", 32'(mif.mem_re), 32'd0);
    check("late_valid_miss", miss_cnt, 32'd0);
    do_fetch(32'h504, 1'b0, st);
    check("refill_stall", 32'(st), 32'd18);
    check("refill_miss", miss_cnt, 32'd1);
    check("refill_hit", hit_cnt, 32'd1);
    check_fill(32'h504);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
